ama_riscv_mmio_uart: RTL and testbench

MMIO UART responder for the core's UART load/store path: a byte stored by the core is serialized 8N1 on `serial_out`, and bytes arriving on `serial_in` are deserialized into a holding register the core loads. It sits in `ama_riscv_core_top` beside IMEM/DMEM, on the far end of the core's `store_to_uart` / `load_from_uart` MMIO strobes.

---
 rtl/ama_riscv_mmio_uart.sv | 201 ++++++++++++++++++++
 tb/tb_ama_riscv_mmio_uart.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_mmio_uart.sv
`timescale 1ns/1ps
// MMIO UART: 8N1 TX from core stores, RX into a load-consumed holding register.
// TX: start bit one cycle after accept, ready low for 10 bit times. RX: valid 2+T/2+9T+1 cycles after the falling edge, overrun overwrites.
module ama_riscv_mmio_uart #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       store_to_uart,
    input  logic [7:0] mmio_uart_data_in,
    output logic       mmio_data_in_ready,
    input  logic       load_from_uart,
    output logic [7:0] mmio_uart_data_out,
    output logic       mmio_data_out_valid,
    input  logic       serial_in,
    output logic       serial_out
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SYMBOL_EDGE_TIME - 1);
    // Two cycles of the half-bit are already spent in synchronizer and edge detect.
    localparam logic [CW-1:0] CNT_START = CW'(SYMBOL_EDGE_TIME / 2 - 2);

    generate
        if (SYMBOL_EDGE_TIME < 4) begin : g_bad_baud
            $error("ama_riscv_mmio_uart: CLOCK_FREQ/BAUD_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    // ---------------- TX ----------------
    uart_state_t   tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_idx, tx_idx_nxt;
    logic [7:0]    tx_shift, tx_shift_nxt;
    logic          tx_bit_nxt;
    logic          tx_last;

    assign tx_last = (tx_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state           <= IDLE;
            tx_cnt             <= '0;
            tx_idx             <= '0;
            tx_shift           <= '0;
            serial_out         <= 1'b1;
            mmio_data_in_ready <= 1'b1;
        end else begin
            tx_state           <= tx_state_nxt;
            tx_cnt             <= tx_cnt_nxt;
            tx_idx             <= tx_idx_nxt;
            tx_shift           <= tx_shift_nxt;
            serial_out         <= tx_bit_nxt;
            mmio_data_in_ready <= (tx_state_nxt == IDLE);
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_idx_nxt   = tx_idx;
        tx_shift_nxt = tx_shift;
        tx_bit_nxt   = serial_out;
        if (tx_state != IDLE) begin
            tx_cnt_nxt = tx_last ? '0 : tx_cnt + CW'(1);
        end
        case (tx_state)
            IDLE: begin
                if (store_to_uart && mmio_data_in_ready) begin
                    tx_state_nxt = START;
                    tx_shift_nxt = mmio_uart_data_in;
                    tx_bit_nxt   = 1'b0;
                end
            end
            START: begin
                if (tx_last) begin
                    tx_state_nxt = DATA;
                    tx_idx_nxt   = '0;
                    tx_bit_nxt   = tx_shift[0];
                end
            end
            DATA: begin
                if (tx_last) begin
                    if (tx_idx == 3'd7) begin
                        tx_state_nxt = STOP;
                        tx_bit_nxt   = 1'b1;
                    end else begin
                        tx_idx_nxt   = tx_idx + 3'd1;
                        tx_shift_nxt = tx_shift >> 1;
                        tx_bit_nxt   = tx_shift[1];
                    end
                end
            end
            STOP: begin
                if (tx_last) begin
                    tx_state_nxt = IDLE;
                end
            end
            default: tx_state_nxt = IDLE;
        endcase
    end

    // ---------------- RX ----------------
    logic          sync1, sync2, sync_prev;
    uart_state_t   rx_state, rx_state_nxt;
    logic [CW-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]    rx_idx, rx_idx_nxt;
    logic [7:0]    rx_shift, rx_shift_nxt;
    logic          rx_done, rx_done_nxt;
    logic          rx_last;

    assign rx_last = (rx_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
            rx_state  <= IDLE;
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_shift  <= '0;
            rx_done   <= 1'b0;
        end else begin
            sync1     <= serial_in;
            sync2     <= sync1;
            sync_prev <= sync2;
            rx_state  <= rx_state_nxt;
            rx_cnt    <= rx_cnt_nxt;
            rx_idx    <= rx_idx_nxt;
            rx_shift  <= rx_shift_nxt;
            rx_done   <= rx_done_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_idx_nxt   = rx_idx;
        rx_shift_nxt = rx_shift;
        rx_done_nxt  = 1'b0;
        case (rx_state)
            IDLE: begin
                if (sync_prev && !sync2) begin
                    rx_state_nxt = START;
                    rx_cnt_nxt   = '0;
                end
            end
            START: begin
                if (rx_cnt == CNT_START) begin
                    rx_cnt_nxt   = '0;
                    rx_idx_nxt   = '0;
                    rx_state_nxt = sync2 ? IDLE : DATA;
                end else begin
                    rx_cnt_nxt = rx_cnt + CW'(1);
                end
            end
            DATA: begin
                if (rx_last) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {sync2, rx_shift[7:1]};
                    if (rx_idx == 3'd7) begin
                        rx_state_nxt = STOP;
                    end else begin
                        rx_idx_nxt = rx_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CW'(1);
                end
            end
            STOP: begin
                if (rx_last) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = IDLE;
                    rx_done_nxt  = sync2;
                end else begin
                    rx_cnt_nxt = rx_cnt + CW'(1);
                end
            end
            default: rx_state_nxt = IDLE;
        endcase
    end

    // A delivery takes priority over a load landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmio_uart_data_out  <= 8'h00;
            mmio_data_out_valid <= 1'b0;
        end else if (rx_done) begin
            mmio_uart_data_out  <= rx_shift;
            mmio_data_out_valid <= 1'b1;
        end else if (load_from_uart && mmio_data_out_valid) begin
            mmio_data_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ama_riscv_mmio_uart.sv
`timescale 1ns/1ps
// Scoreboard bench for ama_riscv_mmio_uart at T=16 clocks per bit.
module tb_ama_riscv_mmio_uart;

    localparam int T   = 16;
    localparam int LAT = 2 + T/2 + 9*T + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       store = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ready;
    logic       load = 1'b0;
    logic [7:0] dout;
    logic       valid;
    logic       serial_in, serial_out;
    logic       drv_rx = 1'b1;
    logic       loopback = 1'b0;

    assign serial_in = loopback ? serial_out : drv_rx;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] dat;
        int         cyc;
    } exp_t;
    exp_t tx_q[$];
    exp_t rx_q[$];

    ama_riscv_mmio_uart #(
        .CLOCK_FREQ(1_600_000),
        .BAUD_RATE (100_000)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .store_to_uart      (store),
        .mmio_uart_data_in  (din),
        .mmio_data_in_ready (ready),
        .load_from_uart     (load),
        .mmio_uart_data_out (dout),
        .mmio_data_out_valid(valid),
        .serial_in          (serial_in),
        .serial_out         (serial_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_store(input logic [7:0] b, input bit accept);
        store = 1'b1;
        din   = b;
        if (accept) tx_q.push_back('{b, cyc + 1});
        tick(1);
        store = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        if (ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: ready still 0 after %0d cycles, required 1", name, n);
        end
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        if (stop_bit) rx_q.push_back('{b, cyc + LAT});
        for (int i = 0; i < 10; i++) begin
            drv_rx = f[i];
            tick(T);
        end
        drv_rx = 1'b1;
        tick(T);
    endtask

    task automatic check_outputs(input string name, input logic so, input logic rdy,
                                 input logic vld, input logic [7:0] dat);
        check({name, "_serial_out"}, int'(serial_out), int'(so));
        check({name, "_ready"},      int'(ready),      int'(rdy));
        check({name, "_valid"},      int'(valid),      int'(vld));
        check({name, "_data_out"},   int'(dout),       int'(dat));
    endtask

    // TX monitor: every cycle of a frame must carry the expected bit with ready low.
    initial begin : tx_mon
        exp_t       e;
        logic [9:0] f;
        int         bad;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && serial_out === 1'b0) begin
                if (tx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: frame start at cycle %0d, none expected", cyc);
                    repeat (10*T) @(negedge clk);
                end else begin
                    e = tx_q.pop_front();
                    f = {1'b1, e.dat, 1'b0};
                    check("tx_start_cycle", cyc, e.cyc);
                    bad = 0;
                    aborted = 1'b0;
                    for (int c = 0; c < 10*T; c++) begin
                        if (c > 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (serial_out !== f[c/T] || ready !== 1'b0) bad++;
                    end
                    if (!aborted) begin
                        check("tx_frame_bad_cycles", bad, 0);
                        @(negedge clk);
                        check("tx_ready_return", int'(ready), 1);
                    end
                end
            end
        end
    end

    // RX monitor: a rising valid or a changed holding register is a delivery.
    initial begin : rx_mon
        exp_t       e;
        logic       prev_valid;
        logic [7:0] prev_data;
        prev_valid = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && ((valid && !prev_valid) || dout !== prev_data)) begin
                if (rx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got byte 0x%0h valid %0b at cycle %0d, none expected",
                             dout, valid, cyc);
                end else begin
                    e = rx_q.pop_front();
                    check("rx_data", int'(dout), int'(e.dat));
                    check("rx_valid", int'(valid), 1);
                    check("rx_cycle", cyc, e.cyc);
                end
            end
            prev_valid = valid;
            prev_data  = dout;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        tick(5);
        check_outputs("reset", 1'b1, 1'b1, 1'b0, 8'h00);
        rst_n = 1'b1;
        tick(3);

        // TX frame and busy-store handling
        tx_store(8'hA5, 1'b1);
        wait_ready("tx_a5");
        tick(3);
        tx_store(8'h3C, 1'b1);
        tick(4);
        tx_store(8'hFF, 1'b0);
        wait_ready("tx_3c");
        tx_store(8'hFF, 1'b1);
        wait_ready("tx_ff");
        tick(20);

        // RX and load semantics
        rx_send(8'h5A, 1'b1);
        tick(5);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        check("load_clears_valid", int'(valid), 0);
        check("load_keeps_data", int'(dout), 8'h5A);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        check("load2_valid", int'(valid), 0);
        check("load2_data", int'(dout), 8'h5A);

        // Glitch, framing error, then a good frame
        drv_rx = 1'b0;
        tick(4);
        drv_rx = 1'b1;
        tick(2*T);
        rx_send(8'h81, 1'b0);
        tick(T);
        check("frame_err_valid", int'(valid), 0);
        rx_send(8'h42, 1'b1);
        tick(5);
        load = 1'b1;
        tick(1);
        load = 1'b0;

        // Overrun, then a load colliding with a delivery
        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        tick(5);
        check("overrun_valid", int'(valid), 1);
        check("overrun_data", int'(dout), 8'h22);
        fork
            rx_send(8'h33, 1'b1);
            begin
                tick(LAT - 1);
                load = 1'b1;
                tick(1);
                load = 1'b0;
            end
        join
        tick(5);
        check("collide_valid", int'(valid), 1);
        check("collide_data", int'(dout), 8'h33);
        load = 1'b1;
        tick(1);
        load = 1'b0;

        // Loopback, then reset in the middle of a frame
        loopback = 1'b1;
        tick(2);
        rx_q.push_back('{8'hC3, cyc + 1 + LAT});
        tx_store(8'hC3, 1'b1);
        wait_ready("loop_c3");
        tick(20);
        check("loop_valid", int'(valid), 1);
        tx_store(8'h99, 1'b1);
        tick(40);
        rst_n = 1'b0;
        #1;
        check_outputs("midframe_reset", 1'b1, 1'b1, 1'b0, 8'h00);
        tick(3);
        rst_n = 1'b1;
        tick(400);
        check("no_rx_after_reset", int'(valid), 0);
        check("rx_queue_drained", rx_q.size(), 0);
        check("tx_queue_drained", tx_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
